// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory arbiter: geometry, FSM states,
// port identifiers and the default clear value.
package maze_pkg;

    localparam int   ADDR_W     = 4;
    localparam int   MAZE_CELLS = 2 ** (2 * ADDR_W);
    localparam logic CLR_VAL    = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } maze_state_e;

    typedef enum logic {
        SOLVER = 1'b0,
        LOADER = 1'b1
    } port_id_e;

endpackage

// File: rtl/maze_clear_engine.sv
// Sweep counter for the clear engine: walks every cell once, x fastest,
// and flags the final cell so the FSM knows when the sweep is complete.
module maze_clear_engine #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_W-1:0] y,
    output logic              last_cell
);

    localparam logic [2*ADDR_W-1:0] CNT_ONE = 1;

    logic [2*ADDR_W-1:0] cnt;

    // The counter wraps naturally to 0 after the last cell, ready for the next sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign x         = cnt[ADDR_W-1:0];
    assign y         = cnt[2*ADDR_W-1:ADDR_W];
    assign last_cell = &cnt;

endmodule

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter for the single-port maze memory shared by the rat
// solver and the maze loader, plus a clear sweep that owns the memory while running.
module maze_mem_arbiter #(
    parameter int   ADDR_W  = maze_pkg::ADDR_W,
    parameter logic CLR_VAL = maze_pkg::CLR_VAL
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              sol_rd,
    input  logic              sol_wr,
    input  logic [ADDR_W-1:0] sol_x,
    input  logic [ADDR_W-1:0] sol_y,
    input  logic              sol_din,
    output logic              sol_gnt,
    output logic              sol_dout,

    input  logic              ld_rd,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_x,
    input  logic [ADDR_W-1:0] ld_y,
    input  logic              ld_din,
    output logic              ld_gnt,
    output logic              ld_dout,

    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,

    output logic [ADDR_W-1:0] mem_x,
    output logic [ADDR_W-1:0] mem_y,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_din,
    input  logic              mem_dout
);

    import maze_pkg::*;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CLEAR = CLEAR;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    port_id_e          last;
    logic              sol_req;
    logic              ld_req;
    logic              arb_en;
    logic              clr_en;
    logic              clr_last;
    logic [ADDR_W-1:0] clr_x;
    logic [ADDR_W-1:0] clr_y;

    assign sol_req = sol_rd | sol_wr;
    assign ld_req  = ld_rd | ld_wr;
    assign arb_en  = (state != ST_CLEAR);
    assign clr_en  = (state == ST_CLEAR);

    // On a conflict the port that was not served most recently wins.
    assign sol_gnt = arb_en & sol_req & (~ld_req | (last == LOADER));
    assign ld_gnt  = arb_en & ld_req & (~sol_req | (last == SOLVER));

    assign clr_busy = (state == ST_CLEAR);
    assign clr_done = (state == ST_DONE);
    assign sol_dout = mem_dout;
    assign ld_dout  = mem_dout;

    maze_clear_engine #(
        .ADDR_W   (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .en       (clr_en),
        .x        (clr_x),
        .y        (clr_y),
        .last_cell(clr_last)
    );

    // Memory bus mux: the sweep has absolute priority, otherwise the granted port.
    always_comb begin
        mem_x   = '0;
        mem_y   = '0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        mem_din = 1'b0;
        if (clr_en) begin
            mem_x   = clr_x;
            mem_y   = clr_y;
            mem_wr  = 1'b1;
            mem_din = CLR_VAL;
        end else if (sol_gnt) begin
            mem_x   = sol_x;
            mem_y   = sol_y;
            mem_rd  = sol_rd;
            mem_wr  = sol_wr;
            mem_din = sol_din;
        end else if (ld_gnt) begin
            mem_x   = ld_x;
            mem_y   = ld_y;
            mem_rd  = ld_rd;
            mem_wr  = ld_wr;
            mem_din = ld_din;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr_start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset to LOADER so the solver wins the very first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= LOADER;
        end else if (sol_gnt) begin
            last <= SOLVER;
        end else if (ld_gnt) begin
            last <= LOADER;
        end
    end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Self-checking bench for maze_mem_arbiter: directed scenarios plus random
// traffic checked against a shadow-memory / round-robin reference model.
module tb_maze_mem_arbiter;

    import maze_pkg::*;

    localparam int AW    = ADDR_W;
    localparam int CELLS = MAZE_CELLS;

    logic          clk;
    logic          rst;
    logic          sol_rd, sol_wr, sol_din, sol_gnt, sol_dout;
    logic [AW-1:0] sol_x, sol_y;
    logic          ld_rd, ld_wr, ld_din, ld_gnt, ld_dout;
    logic [AW-1:0] ld_x, ld_y;
    logic          clr_start, clr_busy, clr_done;
    logic [AW-1:0] mem_x, mem_y;
    logic          mem_rd, mem_wr, mem_din, mem_dout;

    logic          mem_array [CELLS];
    logic          fill_en;
    logic          fill_val;

    logic          shadow [CELLS];
    port_id_e      model_last;
    int            checks;
    int            failures;

    maze_mem_arbiter #(
        .ADDR_W   (AW),
        .CLR_VAL  (CLR_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sol_rd   (sol_rd),
        .sol_wr   (sol_wr),
        .sol_x    (sol_x),
        .sol_y    (sol_y),
        .sol_din  (sol_din),
        .sol_gnt  (sol_gnt),
        .sol_dout (sol_dout),
        .ld_rd    (ld_rd),
        .ld_wr    (ld_wr),
        .ld_x     (ld_x),
        .ld_y     (ld_y),
        .ld_din   (ld_din),
        .ld_gnt   (ld_gnt),
        .ld_dout  (ld_dout),
        .clr_start(clr_start),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .mem_x    (mem_x),
        .mem_y    (mem_y),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port maze memory with a bench-side bulk fill.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < CELLS; i++) mem_array[i] <= fill_val;
        end else if (mem_wr) begin
            mem_array[{mem_y, mem_x}] <= mem_din;
        end
    end

    assign mem_dout = mem_rd ? mem_array[{mem_y, mem_x}] : 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives both request ports just after a falling edge; op = {rd, wr}.
    task automatic applyStimulus(input logic [1:0] s_op, input int sx, input int sy, input logic sdin,
                                 input logic [1:0] l_op, input int lx, input int ly, input logic ldin);
        @(negedge clk);
        {sol_rd, sol_wr} = s_op;
        sol_x   = AW'(sx);
        sol_y   = AW'(sy);
        sol_din = sdin;
        {ld_rd, ld_wr} = l_op;
        ld_x    = AW'(lx);
        ld_y    = AW'(ly);
        ld_din  = ldin;
        #1;
    endtask

    task automatic idleInputs();
        {sol_rd, sol_wr, sol_din, ld_rd, ld_wr, ld_din, clr_start} = '0;
        sol_x = '0; sol_y = '0; ld_x = '0; ld_y = '0;
    endtask

    task automatic fillMemory(input logic val);
        @(negedge clk);
        fill_val = val;
        fill_en  = 1'b1;
        @(negedge clk);
        fill_en  = 1'b0;
        for (int i = 0; i < CELLS; i++) shadow[i] = val;
    endtask

    task automatic applyReset();
        @(negedge clk);
        idleInputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = LOADER;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput(tag, 32'({sol_gnt, sol_dout, ld_gnt, ld_dout, clr_busy, clr_done,
                              mem_x, mem_y, mem_rd, mem_wr, mem_din}), 32'd0);
    endtask

    // Reference model: single requester wins, a conflict goes to whoever was not served last.
    task automatic checkArb(input string tag);
        logic          s_req, l_req, any, e_rd, e_wr, e_din, e_dout;
        logic [AW-1:0] e_x, e_y;
        port_id_e      winner;
        s_req  = sol_rd | sol_wr;
        l_req  = ld_rd | ld_wr;
        any    = s_req | l_req;
        winner = SOLVER;
        if (s_req && l_req) winner = (model_last == SOLVER) ? LOADER : SOLVER;
        else if (l_req)     winner = LOADER;
        {e_rd, e_wr, e_din, e_x, e_y} = '0;
        if (any && winner == SOLVER) {e_rd, e_wr, e_din, e_x, e_y} = {sol_rd, sol_wr, sol_din, sol_x, sol_y};
        if (any && winner == LOADER) {e_rd, e_wr, e_din, e_x, e_y} = {ld_rd, ld_wr, ld_din, ld_x, ld_y};
        e_dout = e_rd ? shadow[{e_y, e_x}] : 1'b0;
        checkOutput($sformatf("%s_gnt", tag), 32'({sol_gnt, ld_gnt}),
                    32'({any && winner == SOLVER, any && winner == LOADER}));
        checkOutput($sformatf("%s_bus", tag), 32'({mem_x, mem_y, mem_rd, mem_wr, mem_din}),
                    32'({e_x, e_y, e_rd, e_wr, e_din}));
        checkOutput($sformatf("%s_dout", tag), 32'({sol_dout, ld_dout}), 32'({e_dout, e_dout}));
        if (any) begin
            if (e_wr) shadow[{e_y, e_x}] = e_din;
            model_last = winner;
        end
    endtask

    task automatic readAll(input string tag);
        for (int i = 0; i < CELLS; i++) begin
            applyStimulus(2'b10, i % (1 << AW), i / (1 << AW), 1'b0, 2'b00, 0, 0, 1'b0);
            checkArb($sformatf("%s_c%0d", tag, i));
        end
    endtask

    initial begin
        logic [1:0] exp_rr [4];
        int         ok_wr, busy_cnt, gnt_err, done_cnt;
        exp_rr   = '{2'b10, 2'b01, 2'b10, 2'b01};
        checks   = 0;
        failures = 0;
        fill_en  = 1'b0;
        fill_val = 1'b0;
        idleInputs();
        rst = 1'b1;
        model_last = LOADER;
        for (int i = 0; i < CELLS; i++) shadow[i] = 1'b0;
        #12;
        checkIdleOutputs("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdleOutputs("reset_release");

        $display("[TB] solver-only read of preset cell");
        fillMemory(1'b1);
        applyStimulus(2'b10, 3, 5, 1'b0, 2'b00, 0, 0, 1'b0);
        checkOutput("rd35_sol_gnt", 32'(sol_gnt), 32'd1);
        checkOutput("rd35_xy", 32'({mem_x, mem_y}), 32'({4'd3, 4'd5}));
        checkOutput("rd35_dout", 32'(sol_dout), 32'd1);
        checkOutput("rd35_ld_gnt", 32'(ld_gnt), 32'd0);
        checkArb("rd35");

        $display("[TB] continuous contention after reset");
        applyReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'b10, 1, 0, 1'b0, 2'b10, 2, 0, 1'b0);
            checkOutput($sformatf("rr_c%0d", c), 32'({sol_gnt, ld_gnt}), 32'(exp_rr[c]));
            checkArb($sformatf("rr_model_c%0d", c));
        end

        $display("[TB] loader write beats solver read after solver grant");
        fillMemory(1'b0);
        applyStimulus(2'b10, 0, 0, 1'b0, 2'b00, 0, 0, 1'b0);
        checkArb("pre_sol");
        applyStimulus(2'b10, 15, 15, 1'b0, 2'b01, 15, 15, 1'b1);
        checkOutput("ffw_gnt", 32'({sol_gnt, ld_gnt}), 32'b01);
        checkArb("ffw");
        applyStimulus(2'b10, 15, 15, 1'b0, 2'b00, 0, 0, 1'b0);
        checkOutput("ffr_dout", 32'(sol_dout), 32'd1);
        checkArb("ffr");

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)));
            checkArb($sformatf("rand_%0d", n));
        end

        $display("[TB] full clear sweep with mid-sweep restart attempt");
        fillMemory(1'b1);
        applyStimulus(2'b10, 7, 7, 1'b0, 2'b00, 0, 0, 1'b0);
        clr_start = 1'b1;
        #1;
        checkArb("clr_kick");
        ok_wr = 0; busy_cnt = 0; gnt_err = 0; done_cnt = 0;
        for (int i = 0; i < CELLS; i++) begin
            applyStimulus(2'b10, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0,
                          2'b01, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
            clr_start = (i == 50);
            #1;
            if (mem_wr && mem_din == CLR_VAL && !mem_rd && {mem_y, mem_x} == 8'(i)) ok_wr++;
            busy_cnt += int'(clr_busy);
            gnt_err  += int'(sol_gnt | ld_gnt);
            done_cnt += int'(clr_done);
        end
        checkOutput("sweep_writes", 32'(ok_wr), 32'(CELLS));
        checkOutput("sweep_busy", 32'(busy_cnt), 32'(CELLS));
        checkOutput("sweep_grants", 32'(gnt_err), 32'd0);
        checkOutput("sweep_early_done", 32'(done_cnt), 32'd0);
        applyStimulus(2'b00, 0, 0, 1'b0, 2'b00, 0, 0, 1'b0);
        clr_start = 1'b0;
        checkOutput("sweep_done_pulse", 32'({clr_done, clr_busy}), 32'b10);
        applyStimulus(2'b00, 0, 0, 1'b0, 2'b00, 0, 0, 1'b0);
        checkOutput("sweep_after", 32'({clr_done, clr_busy}), 32'b00);
        for (int i = 0; i < CELLS; i++) shadow[i] = CLR_VAL;
        readAll("clr_rd");

        $display("[TB] reset during sweep");
        fillMemory(1'b1);
        @(negedge clk);
        idleInputs();
        clr_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            clr_start = 1'b0;
        end
        @(negedge clk);
        #1;
        checkOutput("abort_busy_before", 32'(clr_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkIdleOutputs("abort_async");
        @(negedge clk);
        rst = 1'b0;
        model_last = LOADER;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            done_cnt += int'(clr_done);
            busy_cnt += int'(clr_busy);
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_no_busy", 32'(busy_cnt), 32'd0);
        for (int i = 0; i < 100; i++) shadow[i] = CLR_VAL;
        readAll("abort_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_mem_arbiter.md
# maze_mem_arbiter

Arbitrates the single-port 16x16 1-bit maze memory between two requesters: the rat solver (visited-cell reads and marks) and the maze loader (host wall programming). It also contains a clear engine that sweeps every cell to a fixed value before a new run. It sits between the solver/loader and the maze memory, so the solver no longer drives the memory's X/Y/RD/WR pins directly.

## Interface
Parameters:
- ADDR_W, 4, coordinate width; the maze is 2^ADDR_W x 2^ADDR_W cells.
- CLR_VAL, 1'b0, value written to every cell by a clear sweep.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sol_rd  in  1  solver read request.
- sol_wr  in  1  solver write request.
- sol_x, sol_y  in  ADDR_W each  solver coordinates.
- sol_din  in  1  solver write data.
- sol_gnt  out  1  solver access granted this cycle.
- sol_dout  out  1  read data to solver; valid when sol_gnt.
- ld_rd, ld_wr, ld_x, ld_y, ld_din, ld_gnt, ld_dout: loader port, same widths and meaning as the solver port.
- clr_start  in  1  single-cycle request to start a clear sweep.
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep has completed.
- mem_x, mem_y  out  ADDR_W each  memory coordinates.
- mem_rd, mem_wr  out  1  memory strobes.
- mem_din  out  1  memory write data.
- mem_dout  in  1  memory read data; combinational from mem_x/mem_y when mem_rd is high.

## Operation
- A port requests when rd|wr. If rd and wr are both high, the write is performed and the old cell value is returned on dout.
- FSM states:
  - IDLE: arbitration active. clr_start moves the FSM to CLEAR; requests in that same cycle are still served.
  - CLEAR: both grants are forced to 0. The engine drives mem_wr=1, mem_din=CLR_VAL, mem_x=cnt[ADDR_W-1:0], mem_y=cnt[2*ADDR_W-1:ADDR_W]. cnt is 2*ADDR_W bits and increments every cycle. When cnt reaches all-ones, the FSM moves to DONE and cnt wraps to 0.
  - DONE: clr_done=1 and arbitration is active. The FSM always moves to IDLE on the next edge.
- clr_start is ignored in CLEAR and DONE.
- Arbitration applies in IDLE and DONE, using a round-robin pointer `last` (the port granted most recently).
  - Single requester: it is granted.
  - Both requesting: the port that is not `last` is granted.
  - `last` updates on every cycle with a grant. It holds when no port is granted.
- The granted port's x/y/din/rd/wr are muxed to mem_*. With no grant: mem_rd=mem_wr=0 and mem_x=mem_y=mem_din=0.
- sol_dout and ld_dout both carry mem_dout; each is meaningful only to the granted port.
- A denied requester must hold its request until granted. The arbiter stores nothing for a denied port.

## Timing
- Grants, mem_* outputs and dout are combinational from the requests, the state and `last`. Read latency is 0 cycles; a write takes effect at the next rising edge.
- Worst-case wait under continuous contention is 1 cycle. A clear adds up to 2^(2*ADDR_W) cycles.
- Clear sequence, with clr_start sampled at edge E0:
  - cells 0..255 are written at edges E1..E256 (ADDR_W=4);
  - clr_busy is high from E0 to E256;
  - clr_done is high from E256 to E257;
  - the FSM is back in IDLE after E257.
- Reset values: state=IDLE, cnt=0, last=LOADER (so the solver wins the first conflict). With no requests, all outputs are 0.
- Reset during CLEAR aborts the sweep immediately. Memory contents are then partially cleared, and no clr_done is produced.

## Structure
- A shared package maze_pkg holds:
  - ADDR_W;
  - MAZE_CELLS = 2^(2*ADDR_W);
  - the state enum {IDLE, CLEAR, DONE};
  - the port-id enum {SOLVER, LOADER};
  - CLR_VAL default.
- One sub-module, maze_clear_engine, contains cnt, the terminal-count detection and the coordinate split. The FSM, round-robin logic and muxing stay in the top level.

## Test plan
- Solver-only read of (3,5) with the cell preset to 1: sol_gnt=1 the same cycle, mem_x=3, mem_y=5, sol_dout=1, ld_gnt=0.
- Both ports request continuously for 4 cycles after reset: grants are S, L, S, L, with `last` toggling each cycle.
- Loader writes 1 to (15,15) while the solver reads (15,15) in the same cycle after a solver grant: the loader is granted first. On the next cycle the solver reads 1.
- clr_start with every cell at 1: exactly 256 consecutive mem_wr with din=0, coordinates in order (0,0), (1,0) … (15,15). clr_busy stays high for 256 cycles, followed by one clr_done pulse. Grants are 0 throughout the sweep, and all cells read 0 afterwards.
- clr_start pulsed again mid-sweep: ignored, and total sweep length is still 256.
- rst asserted at sweep cycle 100: outputs go to their reset values asynchronously and clr_done never pulses. Cells 0..99 read CLR_VAL and cells 100..255 are unchanged.
